vector_list_seq: RTL

Frame-level sequencer sitting directly upstream of the vector line rasteriser. On each frame trigger it walks a segment list held in an external synchronous-read memory, presents one segment's endpoints to the rasteriser, pulses its start, and waits for completion. It keeps the endpoints stable while the line is drawn, then fetches the next entry until an entry flagged last. It reports frame completion and list overrun to the display controller.

---
 rtl/vector_list_seq_pkg.sv | 42 ++++
 rtl/vector_list_seq_if.sv | 27 ++
 rtl/vector_list_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vector_list_seq_pkg.sv
// Shared types for the vector list sequencer: FSM encoding and segment-entry layout.
package vector_list_seq_pkg;

   localparam int ENTRY_W  = 33;
   localparam int COORD_W  = 8;

   localparam int LAST_BIT = 32;
   localparam int STAX_MSB = 31;
   localparam int STAX_LSB = 24;
   localparam int STAY_MSB = 23;
   localparam int STAY_LSB = 16;
   localparam int ENDX_MSB = 15;
   localparam int ENDX_LSB = 8;
   localparam int ENDY_MSB = 7;
   localparam int ENDY_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_LAUNCH = 3'd3,
      ST_DRAW   = 3'd4,
      ST_FINISH = 3'd5
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0] stax;
      logic [COORD_W-1:0] stay;
      logic [COORD_W-1:0] endx;
      logic [COORD_W-1:0] endy;
   } seg_t;

   function automatic seg_t entry_seg(input logic [ENTRY_W-1:0] e);
      seg_t s;
      s.stax = e[STAX_MSB:STAX_LSB];
      s.stay = e[STAY_MSB:STAY_LSB];
      s.endx = e[ENDX_MSB:ENDX_LSB];
      s.endy = e[ENDY_MSB:ENDY_LSB];
      return s;
   endfunction

endpackage

// File: rtl/vector_list_seq_if.sv
// Sequencer-side bus: segment-memory read port plus the rasteriser launch/endpoint port.
interface vector_list_seq_if #(
   parameter int ADDR_W = 8
);
   import vector_list_seq_pkg::*;

   logic                mem_rd;
   logic [ADDR_W-1:0]   mem_addr;
   logic [ENTRY_W-1:0]  mem_rdata;
   logic                go;
   logic [COORD_W-1:0]  stax;
   logic [COORD_W-1:0]  stay;
   logic [COORD_W-1:0]  endx;
   logic [COORD_W-1:0]  endy;
   logic                busy;

   modport master (
      output mem_rd, mem_addr, go, stax, stay, endx, endy,
      input  mem_rdata, busy
   );

   modport slave (
      input  mem_rd, mem_addr, go, stax, stay, endx, endy,
      output mem_rdata, busy
   );

endinterface

// File: rtl/vector_list_seq.sv
// Walks a segment list from address 0, launching one rasteriser line per entry until a last flag.
// Latency: frame_start -> mem_rd 1 cycle, -> go 3 cycles; 4 cycles overhead per segment outside busy.
// Backpressure: waits for a busy high->low cycle per line; frame_start dropped unless idle and rasteriser drained.
module vector_list_seq
   import vector_list_seq_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_start,
   vector_list_seq_if.master   bus,
   output logic                frame_busy,
   output logic                frame_done,
   output logic                overrun,
   output logic [ADDR_W:0]     seg_count
);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   seg_t              seg;
   logic              last_r;
   logic              seen_busy;
   logic              accept;
   logic              draw_done;
   logic              at_end;

   // A line is complete only after busy has been observed high, so a launch
   // is never mistaken for completion before the rasteriser reacts.
   assign draw_done = !bus.busy && seen_busy;
   assign at_end    = &addr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      bus.mem_rd = 1'b0;
      bus.go     = 1'b0;
      frame_busy = 1'b1;
      frame_done = 1'b0;
      accept     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            frame_busy = 1'b0;
            if (frame_start && !bus.busy) begin
               accept    = 1'b1;
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            bus.mem_rd = 1'b1;
            state_nxt  = ST_LOAD;
         end
         ST_LOAD: begin
            state_nxt = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            bus.go    = 1'b1;
            state_nxt = ST_DRAW;
         end
         ST_DRAW: begin
            if (draw_done) begin
               state_nxt = (last_r || at_end) ? ST_FINISH : ST_FETCH;
            end
         end
         ST_FINISH: begin
            frame_busy = 1'b0;
            frame_done = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr      <= '0;
         seg       <= '0;
         last_r    <= 1'b0;
         seen_busy <= 1'b0;
         seg_count <= '0;
         overrun   <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  addr      <= '0;
                  seg_count <= '0;
                  overrun   <= 1'b0;
               end
            end
            // Endpoints are only loaded here; the rasteriser reads them
            // combinationally for the whole line.
            ST_LOAD: begin
               seg    <= entry_seg(bus.mem_rdata);
               last_r <= bus.mem_rdata[LAST_BIT];
            end
            ST_LAUNCH: begin
               seg_count <= seg_count + 1'b1;
               seen_busy <= 1'b0;
            end
            ST_DRAW: begin
               if (bus.busy) begin
                  seen_busy <= 1'b1;
               end
               if (draw_done && !last_r) begin
                  if (at_end) begin
                     overrun <= 1'b1;
                  end else begin
                     addr <= addr + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.mem_addr = addr;
   assign bus.stax     = seg.stax;
   assign bus.stay     = seg.stay;
   assign bus.endx     = seg.endx;
   assign bus.endy     = seg.endy;

endmodule
